// File: rtl/tmr_apb_arbiter.sv
// Two-requester round-robin APB master feeding the timer_counter_8bit register port.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module tmr_apb_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic [1:0]              req,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_done,
    output logic [1:0]              req_err,
    output logic [DATA_WIDTH-1:0]   req_rdata,
    output logic                    grant_id,
    output logic                    busy,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, next_state;

    logic       last;
    logic [1:0] eligible;
    logic       winner;
    logic       grant_go;
    logic       complete;
    logic       abort;
    logic [1:0] served_mask;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("tmr_apb_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    assign complete    = (state == ACCESS) && pready;
    assign served_mask = grant_id ? 2'b10 : 2'b01;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt;

    // Counts stalled ACCESS cycles; the abort fires on the stall that would make it TIMEOUT_CYCLES.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            timeout_cnt <= '0;
        end else if (grant_go) begin
            timeout_cnt <= '0;
        end else if ((state == ACCESS) && !pready) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    assign abort = (state == ACCESS) && !pready &&
                   (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    // The cycle carrying a done pulse is a turnaround cycle, giving 4 cycles per transfer.
    always_comb begin
        eligible   = req & ~req_done;
        winner     = (eligible == 2'b11) ? ~last : eligible[1];
        grant_go   = (state == IDLE) && (eligible != 2'b00) && (req_done == 2'b00);
        next_state = state;
        case (state)
            IDLE:    if (grant_go) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (complete || abort) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            grant_id <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
        end else if (grant_go) begin
            grant_id <= winner;
            pwrite   <= req_write[winner];
            paddr    <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata   <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            req_done  <= 2'b00;
            req_err   <= 2'b00;
            req_rdata <= '0;
            last      <= 1'b1;
        end else begin
            req_done  <= 2'b00;
            req_err   <= 2'b00;
            req_rdata <= '0;
            if (complete || abort) begin
                req_done  <= served_mask;
                req_err   <= (abort || pslverr) ? served_mask : 2'b00;
                req_rdata <= (complete && !pwrite) ? prdata : '0;
                last      <= grant_id;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign psel    = busy;
    assign penable = (state == ACCESS);

endmodule

// File: tb/tb_tmr_apb_arbiter.sv
// Directed self-checking bench for tmr_apb_arbiter; inputs change and outputs are
// sampled on the falling edge of pclk.
module tb_tmr_apb_arbiter;

    logic       pclk;
    logic       preset_n;
    logic [1:0] req;
    logic [1:0] req_write;
    logic [5:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0] req_done;
    logic [1:0] req_err;
    logic [7:0] req_rdata;
    logic       grant_id;
    logic       busy;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int errors = 0;
    int checks = 0;

    tmr_apb_arbiter #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .req(req),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_done(req_done),
        .req_err(req_err),
        .req_rdata(req_rdata),
        .grant_id(grant_id),
        .busy(busy),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic next_cycle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        req = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        prdata = 8'h00; pready = 1'b1; pslverr = 1'b0;
        next_cycle(2);
        checks++;
        if ({psel, penable, busy, pwrite, grant_id, req_done, req_err} !== 9'b0 ||
            paddr !== 3'b000 || pwdata !== 8'h00 || req_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got psel=%0b pen=%0b busy=%0b done=%0b paddr=%0h pwdata=%0h, required all zero",
                     psel, penable, busy, req_done, paddr, pwdata);
        end
        preset_n = 1'b1;
        // Start a transfer and kill it with reset in the middle of ACCESS.
        req = 2'b01; req_write = 2'b01; req_addr = 6'b000_011; req_wdata = 16'h0099; pready = 1'b0;
        next_cycle(2);
        checks++;
        if (penable !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_pre_access: got penable=%0b required 1", penable);
        end
        #2 preset_n = 1'b0;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_drop: got psel=%0b penable=%0b busy=%0b required 0 0 0", psel, penable, busy);
        end
        next_cycle(1);
        preset_n = 1'b1; req = 2'b00; pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle(1);
            checks++;
            if (req_done !== 2'b00 || psel !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_no_done: cycle %0d got done=%0b psel=%0b required 0 0", i, req_done, psel);
            end
        end
        // Both request: requester 0 must win the first grant after reset.
        req = 2'b11; req_write = 2'b11; req_addr = 6'b010_011; req_wdata = 16'h3CA1;
        next_cycle(1);
        checks++;
        if (psel !== 1'b1 || grant_id !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_first_grant: got psel=%0b grant=%0b required 1 0", psel, grant_id);
        end
        req = 2'b00;
        next_cycle(2);
        checks++;
        if (req_done !== 2'b01) begin
            errors++; $display("[TB] FAIL reset_first_done: got %0b required 01", req_done);
        end
        next_cycle(1);
    endtask

    task automatic test_single_write();
        req = 2'b01; req_write = 2'b01; req_addr = 6'b000_010; req_wdata = 16'h005A; pready = 1'b1;
        next_cycle(1);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || busy !== 1'b1 || paddr !== 3'b010 ||
            pwdata !== 8'h5A || pwrite !== 1'b1 || grant_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_setup: got psel=%0b pen=%0b paddr=%0h pwdata=%0h pwrite=%0b gid=%0b required 1 0 2 5a 1 0",
                     psel, penable, paddr, pwdata, pwrite, grant_id);
        end
        next_cycle(1);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 3'b010 || pwdata !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL write_access: got psel=%0b pen=%0b paddr=%0h pwdata=%0h required 1 1 2 5a", psel, penable, paddr, pwdata);
        end
        next_cycle(1);
        checks++;
        if (req_done !== 2'b01 || req_err !== 2'b00 || req_rdata !== 8'h00 || psel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_done: got done=%0b err=%0b rdata=%0h psel=%0b required 01 00 0 0", req_done, req_err, req_rdata, psel);
        end
        req = 2'b00;
        next_cycle(1);
        checks++;
        if (req_done !== 2'b00) begin
            errors++; $display("[TB] FAIL write_done_width: got %0b required 00", req_done);
        end
    endtask

    task automatic test_wait_read();
        req = 2'b10; req_write = 2'b00; req_addr = 6'b011_000; req_wdata = 16'h0000;
        pready = 1'b0; prdata = 8'h00; pslverr = 1'b0;
        next_cycle(1);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || grant_id !== 1'b1) begin
            errors++; $display("[TB] FAIL read_setup: got psel=%0b pen=%0b gid=%0b required 1 0 1", psel, penable, grant_id);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle(1);
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 3'b011 || pwrite !== 1'b0 || req_done !== 2'b00) begin
                errors++;
                $display("[TB] FAIL read_wait: cycle %0d got psel=%0b pen=%0b paddr=%0h pwrite=%0b done=%0b required 1 1 3 0 00",
                         i, psel, penable, paddr, pwrite, req_done);
            end
        end
        pready = 1'b1; prdata = 8'h7F; pslverr = 1'b1;
        next_cycle(1);
        checks++;
        if (req_done !== 2'b10 || req_err !== 2'b10 || req_rdata !== 8'h7F || psel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_done: got done=%0b err=%0b rdata=%0h psel=%0b required 10 10 7f 0", req_done, req_err, req_rdata, psel);
        end
        req = 2'b00; prdata = 8'h00; pslverr = 1'b0;
        next_cycle(1);
        checks++;
        if (req_done !== 2'b00 || req_err !== 2'b00 || req_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL read_pulse_end: got done=%0b err=%0b rdata=%0h required 00 00 0", req_done, req_err, req_rdata);
        end
    endtask

    task automatic test_contention();
        logic       exp_id;
        logic [2:0] exp_addr;
        logic [7:0] exp_data;
        req = 2'b11; req_write = 2'b11; req_addr = 6'b010_011; req_wdata = 16'h3CA1; pready = 1'b1;
        exp_id = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_addr = exp_id ? 3'b010 : 3'b011;
            exp_data = exp_id ? 8'h3C : 8'hA1;
            next_cycle(1);
            checks++;
            if (psel !== 1'b1 || penable !== 1'b0 || grant_id !== exp_id || paddr !== exp_addr || pwdata !== exp_data) begin
                errors++;
                $display("[TB] FAIL contend_setup: xfer %0d got psel=%0b pen=%0b gid=%0b paddr=%0h pwdata=%0h required 1 0 %0b %0h %0h",
                         k, psel, penable, grant_id, paddr, pwdata, exp_id, exp_addr, exp_data);
            end
            next_cycle(1);
            checks++;
            if (penable !== 1'b1) begin
                errors++; $display("[TB] FAIL contend_access: xfer %0d got penable=%0b required 1", k, penable);
            end
            next_cycle(1);
            checks++;
            if (req_done !== (exp_id ? 2'b10 : 2'b01) || psel !== 1'b0) begin
                errors++;
                $display("[TB] FAIL contend_done: xfer %0d got done=%0b psel=%0b required %0b 0",
                         k, req_done, psel, (exp_id ? 2'b10 : 2'b01));
            end
            if (k == 3) req = 2'b00;
            next_cycle(1);
            checks++;
            if (req_done !== 2'b00 || psel !== 1'b0) begin
                errors++; $display("[TB] FAIL contend_gap: xfer %0d got done=%0b psel=%0b required 00 0", k, req_done, psel);
            end
            exp_id = ~exp_id;
        end
    endtask

    task automatic test_withdraw();
        req = 2'b01; req_write = 2'b01; req_addr = 6'b000_010; req_wdata = 16'h0011; pready = 1'b0;
        next_cycle(2);
        req = 2'b11;
        next_cycle(1);
        req = 2'b01; pready = 1'b1;
        next_cycle(1);
        checks++;
        if (req_done !== 2'b01 || grant_id !== 1'b0) begin
            errors++; $display("[TB] FAIL withdraw_done: got done=%0b gid=%0b required 01 0", req_done, grant_id);
        end
        req = 2'b00;
        for (int i = 0; i < 6; i++) begin
            next_cycle(1);
            checks++;
            if (psel !== 1'b0 || grant_id !== 1'b0 || req_done !== 2'b00) begin
                errors++;
                $display("[TB] FAIL withdraw_no_grant: cycle %0d got psel=%0b gid=%0b done=%0b required 0 0 00", i, psel, grant_id, req_done);
            end
        end
    endtask

    task automatic test_timeout();
        req = 2'b01; req_write = 2'b00; req_addr = 6'b000_011; pready = 1'b0; prdata = 8'hEE;
        next_cycle(1);
`ifdef APB_TIMEOUT_EN
        next_cycle(16);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || req_done !== 2'b00) begin
            errors++; $display("[TB] FAIL timeout_last_access: got psel=%0b pen=%0b done=%0b required 1 1 00", psel, penable, req_done);
        end
        next_cycle(1);
        checks++;
        if (req_done !== 2'b01 || req_err !== 2'b01 || req_rdata !== 8'h00 || psel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_abort: got done=%0b err=%0b rdata=%0h psel=%0b required 01 01 0 0", req_done, req_err, req_rdata, psel);
        end
        req = 2'b00;
        next_cycle(1);
        req = 2'b01; pready = 1'b1; prdata = 8'h42;
        next_cycle(3);
        checks++;
        if (req_done !== 2'b01 || req_err !== 2'b00 || req_rdata !== 8'h42) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got done=%0b err=%0b rdata=%0h required 01 00 42", req_done, req_err, req_rdata);
        end
`else
        for (int i = 0; i < 20; i++) begin
            next_cycle(1);
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || req_done !== 2'b00) begin
                errors++;
                $display("[TB] FAIL stall_hold: cycle %0d got psel=%0b pen=%0b done=%0b required 1 1 00", i, psel, penable, req_done);
            end
        end
        pready = 1'b1; prdata = 8'h42;
        next_cycle(1);
        checks++;
        if (req_done !== 2'b01 || req_err !== 2'b00 || req_rdata !== 8'h42) begin
            errors++;
            $display("[TB] FAIL stall_release: got done=%0b err=%0b rdata=%0h required 01 00 42", req_done, req_err, req_rdata);
        end
`endif
        req = 2'b00;
        next_cycle(2);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wait_read();
        test_contention();
        test_withdraw();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
